// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 raster constants, widths and sync bundle type
// shared by the VGA scan controller and its sync delay line.
package vga_timing_pkg;
    localparam int H_ACTIVE  = 640;
    localparam int H_FP      = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BP      = 48;
    localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_ACTIVE  = 480;
    localparam int V_FP      = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BP      = 33;
    localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int PIX_COUNT = H_ACTIVE * V_ACTIVE;
    localparam int ADDR_W    = 19;
    localparam int CNT_W     = 10;

    typedef logic [CNT_W-1:0]  cnt_t;
    typedef logic [ADDR_W-1:0] addr_t;
    typedef struct packed {
        logic de;
        logic hs;
        logic vs;
    } sync_t;

    localparam sync_t SYNC_RST = '{de: 1'b0, hs: 1'b1, vs: 1'b1};

    function automatic logic in_range(input cnt_t x, input cnt_t lo, input cnt_t hi);
        return (x >= lo) && (x < hi);
    endfunction
endpackage

// File: rtl/vga_sync_delay.sv
// vga_sync_delay: reset-cleared shift register that ages {de,hs,vs} by DEPTH
// clocks so sync and blanking line up with the printer's colour latency.
module vga_sync_delay #(
    parameter int             W       = 3,
    parameter int             DEPTH   = 2,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);
    generate
        if (DEPTH == 0) begin : g_bypass
            assign o_q = i_d;
        end else begin : g_pipe
            logic [W-1:0] r_sr [DEPTH];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) r_sr[i] <= RST_VAL;
                end else begin
                    r_sr[0] <= i_d;
                    for (int i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
                end
            end
            assign o_q = r_sr[DEPTH-1];
        end
    endgenerate
endmodule

// File: rtl/vga_scan_ctrl.sv
// vga_scan_ctrl: VGA raster generator feeding pixel addresses to the printer and
// driving latency-aligned sync plus blank-gated colour to the pins.
module vga_scan_ctrl
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int PIPE_LAT = 2,
    parameter int H_ACT    = H_ACTIVE,
    parameter int H_FRONT  = H_FP,
    parameter int H_SW     = H_SYNC,
    parameter int H_BACK   = H_BP,
    parameter int V_ACT    = V_ACTIVE,
    parameter int V_FRONT  = V_FP,
    parameter int V_SW     = V_SYNC,
    parameter int V_BACK   = V_BP
) (
    input  logic              CLK_100MHz,
    input  logic              rst_n,
    input  logic [3:0]        pix_R,
    input  logic [3:0]        pix_G,
    input  logic [3:0]        pix_B,
    output logic [ADDR_W-1:0] pix_addr,
    output logic [CNT_W-1:0]  h_cnt,
    output logic [CNT_W-1:0]  v_cnt,
    output logic              frame_tick,
    output logic              VGA_HS,
    output logic              VGA_VS,
    output logic [3:0]        VGA_R,
    output logic [3:0]        VGA_G,
    output logic [3:0]        VGA_B
);
    localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(CLK_DIV - 1);
    localparam cnt_t             H_MAX    = cnt_t'(H_ACT + H_FRONT + H_SW + H_BACK - 1);
    localparam cnt_t             V_MAX    = cnt_t'(V_ACT + V_FRONT + V_SW + V_BACK - 1);
    localparam cnt_t             H_DE     = cnt_t'(H_ACT);
    localparam cnt_t             V_DE     = cnt_t'(V_ACT);
    localparam cnt_t             HS_ON    = cnt_t'(H_ACT + H_FRONT);
    localparam cnt_t             HS_OFF   = cnt_t'(H_ACT + H_FRONT + H_SW);
    localparam cnt_t             VS_ON    = cnt_t'(V_ACT + V_FRONT);
    localparam cnt_t             VS_OFF   = cnt_t'(V_ACT + V_FRONT + V_SW);
    localparam cnt_t             V_LAST   = cnt_t'(V_ACT - 1);
    localparam addr_t            ADDR_MAX = addr_t'(H_ACT * V_ACT - 1);

    logic [DIV_W-1:0] r_div;
    cnt_t             r_h, r_v;
    addr_t            r_addr;
    logic             r_tick, r_hs, r_vs;
    logic [3:0]       r_r, r_g, r_b;
    logic             w_pix_en, w_h_wrap;
    sync_t            w_sync, w_sync_dly;

    assign w_pix_en = (r_div == DIV_MAX);
    assign w_h_wrap = (r_h == H_MAX);
    assign w_sync   = '{de: (r_h < H_DE) && (r_v < V_DE),
                        hs: !in_range(r_h, HS_ON, HS_OFF),
                        vs: !in_range(r_v, VS_ON, VS_OFF)};

    // pix_addr only advances on active pixels, so blanking holds the next address to fetch
    always_ff @(posedge CLK_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_div  <= '0;
            r_h    <= '0;
            r_v    <= '0;
            r_addr <= '0;
            r_tick <= 1'b0;
        end else begin
            r_div  <= w_pix_en ? '0 : r_div + 1'b1;
            r_tick <= w_pix_en && w_h_wrap && (r_v == V_LAST);
            if (w_pix_en) begin
                r_h <= w_h_wrap ? '0 : r_h + 1'b1;
                if (w_h_wrap) r_v <= (r_v == V_MAX) ? '0 : r_v + 1'b1;
                if (w_sync.de) r_addr <= (r_addr == ADDR_MAX) ? '0 : r_addr + 1'b1;
            end
        end
    end

    vga_sync_delay #(
        .W       (3),
        .DEPTH   (PIPE_LAT),
        .RST_VAL (SYNC_RST)
    ) u_sync_delay (
        .clk   (CLK_100MHz),
        .rst_n (rst_n),
        .i_d   (w_sync),
        .o_q   (w_sync_dly)
    );

    always_ff @(posedge CLK_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_hs <= 1'b1;
            r_vs <= 1'b1;
            r_r  <= 4'h0;
            r_g  <= 4'h0;
            r_b  <= 4'h0;
        end else begin
            r_hs <= w_sync_dly.hs;
            r_vs <= w_sync_dly.vs;
            r_r  <= w_sync_dly.de ? pix_R : 4'h0;
            r_g  <= w_sync_dly.de ? pix_G : 4'h0;
            r_b  <= w_sync_dly.de ? pix_B : 4'h0;
        end
    end

    assign pix_addr   = r_addr;
    assign h_cnt      = r_h;
    assign v_cnt      = r_v;
    assign frame_tick = r_tick;
    assign VGA_HS     = r_hs;
    assign VGA_VS     = r_vs;
    assign VGA_R      = r_r;
    assign VGA_G      = r_g;
    assign VGA_B      = r_b;
endmodule

// File: tb/tb_vga_scan_ctrl.sv
// tb_vga_scan_ctrl: scan controller on a shrunken raster against a raster model
// derived from elapsed clock count, with a latency-2 printer stand-in.
module tb_vga_scan_ctrl;
    localparam int DIV = 4, LAT = 2;
    localparam int HA = 40, HF = 2, HSW = 3, HB = 2, HT = HA + HF + HSW + HB;
    localparam int VA = 30, VF = 2, VSW = 1, VB = 2, VT = VA + VF + VSW + VB;
    localparam int FT = HT * VT;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic [3:0]  pix_R, pix_G, pix_B, VGA_R, VGA_G, VGA_B;
    logic [18:0] pix_addr, p1, p2;
    logic [9:0]  h_cnt, v_cnt;
    logic        frame_tick, VGA_HS, VGA_VS;
    int          n = 0, tests = 0, fails = 0, ticks = 0;
    int          hs_run = 0, vs_run = 0, last_fall = -1;
    logic        prev_hs = 1'b1;

    always #5 clk = ~clk;

    vga_scan_ctrl #(
        .CLK_DIV(DIV), .PIPE_LAT(LAT),
        .H_ACT(HA), .H_FRONT(HF), .H_SW(HSW), .H_BACK(HB),
        .V_ACT(VA), .V_FRONT(VF), .V_SW(VSW), .V_BACK(VB)
    ) dut (
        .CLK_100MHz(clk), .rst_n(rst_n),
        .pix_R(pix_R), .pix_G(pix_G), .pix_B(pix_B),
        .pix_addr(pix_addr), .h_cnt(h_cnt), .v_cnt(v_cnt), .frame_tick(frame_tick),
        .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B)
    );

    // printer stand-in: colour is a function of the address issued two clocks earlier
    always @(posedge clk) begin
        p1 <= pix_addr;
        p2 <= p1;
    end
    assign pix_R = p2[3:0];
    assign pix_G = p2[7:4];
    assign pix_B = p2[11:8];

    function automatic int ex_addr(input int p);
        int f = p % FT;
        int h = f % HT;
        int v = f / HT;
        if (v >= VA) return 0;
        return (v * HA + ((h < HA) ? h : HA)) % (HA * VA);
    endfunction

    function automatic logic [2:0] ex_sync(input int p);
        int h = p % HT;
        int v = (p / HT) % VT;
        return {(h < HA) && (v < VA),
                !((h >= HA + HF) && (h < HA + HF + HSW)),
                !((v >= VA + VF) && (v < VA + VF + VSW))};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            if (fails <= 10) $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, got, exp, n);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_h"}, 32'(h_cnt), 32'd0);
        chk({tag, "_v"}, 32'(v_cnt), 32'd0);
        chk({tag, "_addr"}, 32'(pix_addr), 32'd0);
        chk({tag, "_tick"}, 32'(frame_tick), 32'd0);
        chk({tag, "_hsvs"}, 32'({VGA_HS, VGA_VS}), 32'd3);
        chk({tag, "_rgb"}, 32'({VGA_R, VGA_G, VGA_B}), 32'd0);
    endtask

    task automatic step();
        int p, q, a;
        logic [2:0] s;
        @(posedge clk);
        n++;
        @(negedge clk);
        p = n / DIV;
        chk("h_cnt", 32'(h_cnt), 32'(p % HT));
        chk("v_cnt", 32'(v_cnt), 32'((p / HT) % VT));
        chk("pix_addr", 32'(pix_addr), 32'(ex_addr(p)));
        chk("frame_tick", 32'(frame_tick), 32'((n % DIV == 0) && (p % FT == VA * HT)));
        if (n < LAT + 1) begin
            s = 3'b011;
            a = 0;
        end else begin
            q = (n - LAT - 1) / DIV;
            s = ex_sync(q);
            a = ex_addr(q);
        end
        chk("VGA_HS", 32'(VGA_HS), 32'(s[1]));
        chk("VGA_VS", 32'(VGA_VS), 32'(s[0]));
        chk("VGA_RGB", 32'({VGA_R, VGA_G, VGA_B}), s[2] ? 32'({a[3:0], a[7:4], a[11:8]}) : 32'd0);
        if (frame_tick) ticks++;
        if (prev_hs && !VGA_HS) begin
            if (last_fall >= 0) chk("hs_period", n - last_fall, HT * DIV);
            last_fall = n;
        end
        prev_hs = VGA_HS;
        if (!VGA_HS) hs_run++;
        else if (hs_run != 0) begin
            chk("hs_low_clk", hs_run, HSW * DIV);
            hs_run = 0;
        end
        if (!VGA_VS) vs_run++;
        else if (vs_run != 0) begin
            chk("vs_low_clk", vs_run, VSW * HT * DIV);
            vs_run = 0;
        end
    endtask

    // entered at a falling edge; asserts reset between edges, then releases at a falling edge
    task automatic do_reset(input int hold);
        #1 rst_n = 1'b0;
        #1 chk_reset("async_rst");
        repeat (hold) begin
            @(negedge clk);
            chk_reset("rst_hold");
        end
        rst_n = 1'b1;
        n = 0;
        ticks = 0;
        hs_run = 0;
        vs_run = 0;
        last_fall = -1;
        prev_hs = 1'b1;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_reset("por");
        rst_n = 1'b1;
        repeat (3) step();
        chk("pre_pix_en_h", 32'(h_cnt), 32'd0);
        step();
        chk("first_pix_en_h", 32'(h_cnt), 32'd1);
        repeat (2 * FT * DIV + 400) step();
        chk("ticks_2frames", ticks, (n / DIV >= VA * HT) ? (n / DIV - VA * HT) / FT + 1 : 0);
        for (int k = 0; k < 3; k++) begin
            do_reset($urandom_range(1, 6));
            repeat ($urandom_range(200, FT * DIV)) step();
        end
        do_reset(2);
        repeat ((15 * HT + 20) * DIV) step();
        chk("mid_line_h", 32'(h_cnt), 32'd20);
        chk("mid_line_v", 32'(v_cnt), 32'd15);
        do_reset(0);
        repeat (3 * HT * DIV) step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
